uart_rx_word_packer: RTL and testbench
======================================

// Module: uart_rx_word_packer
// PURPOSE
//  Consumer of the UART receive FIFO. Pops received bytes, hunts for a sync byte, then packs
//  NBYTES payload bytes little-endian into one word and checks it against a trailing XOR
//  checksum byte. Delivers the word over a valid/ready handshake to the core-side bus logic.
//  Reports checksum errors and inter-byte timeouts.
// PARAMETERS
//  NBYTES   4       payload bytes per word; word width = 8*NBYTES
//  SYNC     8'hA5   frame start byte
//  TIMEOUT  1000    max i_clk cycles waiting for the next byte inside a frame
//  TO_BITS  10      width of timeout counter; must satisfy 2**TO_BITS > TIMEOUT
// PORTS
//  i_clk        in   1           system clock
//  i_reset      in   1           asynchronous, active-high reset
//  i_empty      in   1           RX FIFO empty flag
//  i_rd_data    in   8           RX FIFO head byte; valid whenever i_empty=0
//  o_rd         out  1           FIFO pop strobe; head byte is consumed in the same cycle
//  o_word       out  8*NBYTES    packed word; byte 0 is the first received byte, in bits [7:0]
//  o_valid      out  1           o_word valid; held until accepted
//  i_ready      in   1           downstream accept; transfer occurs when o_valid & i_ready
//  o_chk_err    out  1           1-cycle pulse: checksum mismatch, frame dropped
//  o_timeout    out  1           1-cycle pulse: inter-byte timeout, frame aborted
// BEHAVIOUR
//  Reset: state=HUNT; all counters 0; o_word=0; o_rd, o_valid, o_chk_err, o_timeout = 0.
//  o_rd = ~i_empty in HUNT, DATA and CHK (combinational); o_rd = 0 in OUT. Never pops while empty.
//  HUNT: each popped byte != SYNC is discarded. Byte == SYNC -> DATA, byte_cnt=0, chk=0, to_cnt=0.
//  DATA: on pop, write byte into o_word lane byte_cnt; chk ^= byte; byte_cnt++.
//        On the pop with byte_cnt == NBYTES-1 -> CHK.
//        SYNC-valued bytes inside a frame are payload; no resync.
//  CHK:  on pop, compare byte with chk.
//        Equal -> OUT, o_valid=1 from the next cycle (1-cycle latency after the checksum pop).
//        Unequal -> o_chk_err pulse for 1 cycle, -> HUNT; o_word keeps the partial value.
//  OUT:  o_valid and o_word held stable with no pops.
//        On o_valid & i_ready: o_valid=0 next cycle, -> HUNT. Bytes arriving meanwhile stay in the FIFO.
//  Timeout, DATA/CHK only:
//   - to_cnt clears on every pop and increments each cycle with i_empty=1.
//   - When to_cnt == TIMEOUT-1 and still empty: o_timeout pulse for 1 cycle, -> HUNT.
//   - A pop in the same cycle as the limit wins (no timeout).
//   - to_cnt is frozen at 0 in HUNT and OUT.
//  Pulses o_chk_err and o_timeout are registered and never assert together.
//  Asynchronous reset mid-frame discards the partial word. A FIFO byte already popped is lost.
//  byte_cnt width is clog2(NBYTES). Checksum is a pure 8-bit XOR of payload bytes; SYNC is excluded.
// STRUCTURE
//  Shared header uart_defs.vh: state encodings HUNT=2'd0, DATA=2'd1, CHK=2'd2, OUT=2'd3;
//  default SYNC byte; clog2 function.
//  One sub-module, timeout_counter #(.N(TO_BITS), .LIMIT(TIMEOUT)).
//   - inputs: i_clk, i_reset, i_clr, i_en
//   - output: o_expired
//  FSM next-state/output logic and byte lane write live in this module.
// TESTING
//  (bench: baud_rate_generator + uart_rx + FIFO feeding this block; i_ready driven by the bench)
//  1. Send A5,78,56,34,12,chk=08, i_ready=1.
//     -> o_valid 1 cycle after the chk pop; o_word=32'h12345678; no error pulses.
//  2. Send 00,FF,A5,01,02,03,04,04.
//     -> 00 and FF discarded; o_word=32'h04030201.
//  3. Send A5,01,02,03,04,05 (bad chk).
//     -> o_chk_err pulses once; o_valid stays 0; next good frame is accepted normally.
//  4. Send A5,11,22 then idle > TIMEOUT cycles.
//     -> o_timeout pulses once, TIMEOUT cycles after the 22 pop; block returns to HUNT.
//  5. Two back-to-back good frames with i_ready=0 for 50 cycles.
//     -> first word held stable, o_rd=0 throughout; second frame stays in the FIFO.
//     After i_ready, both words are delivered in order.
//  6. Assert i_reset after the 2nd payload byte of a frame.
//     -> all outputs 0 immediately; a following good frame decodes correctly.

Source files
------------

// File: rtl/uart_rx_word_packer_pkg.sv
// Shared definitions for the UART receive word packer: FSM states, default sync byte, width helper.
package uart_rx_word_packer_pkg;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        DATA = 2'd1,
        CHK  = 2'd2,
        OUT  = 2'd3
    } state_t;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    // Minimum 1 bit so a single-byte word still gets a legal counter.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/uart_rx_word_packer_timeout_counter.sv
// Inter-byte idle counter; flags expiry in the cycle the count reaches LIMIT-1 while still enabled.
module timeout_counter #(
    parameter int N     = 10,
    parameter int LIMIT = 1000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    logic [N-1:0] cnt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)    cnt <= '0;
        else if (i_clr) cnt <= '0;
        else if (i_en)  cnt <= cnt + 1'b1;
    end

    assign o_expired = i_en && (cnt == N'(LIMIT - 1));

endmodule

// File: rtl/uart_rx_word_packer.sv
// Pops the RX FIFO, hunts for a sync byte, packs NBYTES payload bytes little-endian and
// delivers the word over valid/ready once its trailing XOR checksum matches.
module uart_rx_word_packer
    import uart_rx_word_packer_pkg::*;
#(
    parameter int         NBYTES  = 4,
    parameter logic [7:0] SYNC    = SYNC_DEFAULT,
    parameter int         TIMEOUT = 1000,
    parameter int         TO_BITS = 10
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_empty,
    input  logic [7:0]            i_rd_data,
    output logic                  o_rd,
    output logic [8*NBYTES-1:0]   o_word,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_chk_err,
    output logic                  o_timeout
);

    localparam int CNT_W = clog2(NBYTES);

    state_t           state;
    logic [CNT_W-1:0] byte_cnt;
    logic [7:0]       chk;
    logic             in_frame;
    logic             expired;

    assign in_frame = (state == DATA) || (state == CHK);
    // Held off during reset so a byte is never consumed by a block that cannot store it.
    assign o_rd     = ~i_reset & ~i_empty & (state != OUT);

    timeout_counter #(.N(TO_BITS), .LIMIT(TIMEOUT)) u_timeout (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_clr     (~in_frame | o_rd | expired),
        .i_en      (in_frame & i_empty),
        .o_expired (expired)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state     <= HUNT;
            byte_cnt  <= '0;
            chk       <= '0;
            o_word    <= '0;
            o_valid   <= 1'b0;
            o_chk_err <= 1'b0;
            o_timeout <= 1'b0;
        end else begin
            o_chk_err <= 1'b0;
            o_timeout <= 1'b0;
            case (state)
                HUNT: begin
                    if (o_rd && (i_rd_data == SYNC)) begin
                        state    <= DATA;
                        byte_cnt <= '0;
                        chk      <= '0;
                    end
                end
                DATA: begin
                    if (o_rd) begin
                        o_word[{byte_cnt, 3'b000} +: 8] <= i_rd_data;
                        chk      <= chk ^ i_rd_data;
                        byte_cnt <= byte_cnt + 1'b1;
                        if (byte_cnt == CNT_W'(NBYTES - 1)) state <= CHK;
                    end else if (expired) begin
                        o_timeout <= 1'b1;
                        state     <= HUNT;
                    end
                end
                CHK: begin
                    if (o_rd) begin
                        if (i_rd_data == chk) begin
                            o_valid <= 1'b1;
                            state   <= OUT;
                        end else begin
                            o_chk_err <= 1'b1;
                            state     <= HUNT;
                        end
                    end else if (expired) begin
                        o_timeout <= 1'b1;
                        state     <= HUNT;
                    end
                end
                OUT: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        state   <= HUNT;
                    end
                end
                default: state <= HUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_word_packer.sv
// Randomized bench: a queue stands in for the RX FIFO and a stream-level frame parser predicts events.
module tb_uart_rx_word_packer;

    localparam int         NB = 4;
    localparam int         TO = 1000;
    localparam logic [7:0] SY = 8'hA5;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_empty = 1'b1;
    logic [7:0]  i_rd_data = 8'h00;
    logic        i_ready = 1'b0;
    logic        o_rd, o_valid, o_chk_err, o_timeout;
    logic [31:0] o_word;

    always #5 i_clk = ~i_clk;

    uart_rx_word_packer #(.NBYTES(NB), .SYNC(SY), .TIMEOUT(TO), .TO_BITS(10)) dut (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_empty   (i_empty),
        .i_rd_data (i_rd_data),
        .o_rd      (o_rd),
        .o_word    (o_word),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_chk_err (o_chk_err),
        .o_timeout (o_timeout)
    );

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // FIFO model: flags reflect the queue as of the last clock edge.
    logic [7:0] fifo[$];
    int cyc = 0;
    int pop_edge = -1;

    always @(posedge i_clk) begin
        cyc <= cyc + 1;
        if (i_reset) begin
            fifo.delete();
        end else if (o_rd && fifo.size() != 0) begin
            void'(fifo.pop_front());
            pop_edge <= cyc + 1;
        end
        i_empty   <= (fifo.size() == 0);
        i_rd_data <= (fifo.size() != 0) ? fifo[0] : 8'h00;
    end

    // Reference model: parses the byte stream into expected events (0 word, 1 chk error, 2 timeout).
    typedef struct { int kind; logic [31:0] w; } ev_t;
    ev_t        exp_q[$];
    bit         m_in = 1'b0;
    logic [7:0] m_bytes[$];

    function automatic void model_byte(input logic [7:0] b);
        logic [7:0]  x;
        logic [31:0] w;
        ev_t         e;
        if (!m_in) begin
            if (b == SY) begin
                m_in = 1'b1;
                m_bytes.delete();
            end
        end else begin
            m_bytes.push_back(b);
            if (m_bytes.size() == NB + 1) begin
                x = 8'h00;
                w = 32'h0;
                for (int i = 0; i < NB; i++) begin
                    x = x ^ m_bytes[i];
                    w = w | (32'(m_bytes[i]) << (8 * i));
                end
                e.kind = (m_bytes[NB] == x) ? 0 : 1;
                e.w    = (e.kind == 0) ? w : 32'h0;
                exp_q.push_back(e);
                m_in = 1'b0;
            end
        end
    endfunction

    function automatic void model_idle();
        ev_t e;
        if (m_in) begin
            e.kind = 2;
            e.w    = 32'h0;
            exp_q.push_back(e);
        end
        m_in = 1'b0;
    endfunction

    task automatic expect_ev(input int kind, input logic [31:0] w);
        ev_t e;
        if (exp_q.size() == 0) begin
            check_eq("spurious_event", 32'(kind), 32'hFFFF_FFFF);
        end else begin
            e = exp_q.pop_front();
            check_eq("event_kind", 32'(kind), 32'(e.kind));
            if (e.kind == 0) check_eq("word", w, e.w);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    logic        pv = 1'b0;
    logic [31:0] pword = 32'h0;

    always @(negedge i_clk) begin
        if (i_reset) begin
            pv <= 1'b0;
        end else begin
            check_eq("no_pop_empty", 32'(o_rd & i_empty), 32'h0);
            check_eq("pulse_excl", 32'(o_chk_err & o_timeout), 32'h0);
            if (o_valid) check_eq("rd_in_out", 32'(o_rd), 32'h0);
            if (o_valid && pv) check_eq("word_hold", o_word, pword);
            if (o_valid && !pv) check_eq("valid_lat", 32'(cyc - pop_edge), 32'h0);
            if (o_timeout) check_eq("timeout_lat", 32'(cyc - pop_edge), 32'(TO));
            if (o_valid && i_ready) expect_ev(0, o_word);
            if (o_chk_err) expect_ev(1, 32'h0);
            if (o_timeout) expect_ev(2, 32'h0);
            pv    <= o_valid;
            pword <= o_word;
        end
    end

    bit rand_ready = 1'b0;

    task automatic tick();
        @(posedge i_clk);
        #1;
        if (rand_ready) i_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic push_byte(input logic [7:0] b, input int gap);
        fifo.push_back(b);
        model_byte(b);
        repeat (gap) tick();
    endtask

    task automatic send_frame(input logic [31:0] w, input bit good, input int gmax);
        logic [7:0] x;
        logic [7:0] wb;
        x = 8'h00;
        push_byte(SY, $urandom_range(0, gmax));
        for (int i = 0; i < NB; i++) begin
            wb = w[8*i +: 8];
            x  = x ^ wb;
            push_byte(wb, $urandom_range(0, gmax));
        end
        if (!good) x = x ^ 8'($urandom_range(1, 255));
        push_byte(x, $urandom_range(0, gmax));
    endtask

    task automatic wait_drain(input int limit);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || fifo.size() != 0 || o_valid) && n < limit) begin
            tick();
            n++;
        end
        repeat (3) tick();
        check_eq("drain_events", 32'(exp_q.size()), 32'h0);
        check_eq("drain_fifo", 32'(fifo.size()), 32'h0);
    endtask

    initial begin
        #1 i_reset = 1'b1;
        repeat (3) tick();
        check_eq("rst_valid", 32'(o_valid), 32'h0);
        check_eq("rst_rd", 32'(o_rd), 32'h0);
        check_eq("rst_word", o_word, 32'h0);
        check_eq("rst_chk_err", 32'(o_chk_err), 32'h0);
        check_eq("rst_timeout", 32'(o_timeout), 32'h0);
        i_reset = 1'b0;
        i_ready = 1'b1;
        tick();

        // Known frames: plain, garbage before sync, bad checksum then good.
        send_frame(32'h12345678, 1'b1, 0);
        wait_drain(200);
        push_byte(8'h00, 0);
        push_byte(8'hFF, 0);
        send_frame(32'h04030201, 1'b1, 2);
        wait_drain(200);
        send_frame(32'h04030201, 1'b0, 0);
        send_frame(32'hA5A5_00A5, 1'b1, 1);
        wait_drain(200);

        // Partial frame followed by silence.
        push_byte(SY, 0);
        push_byte(8'h11, 0);
        push_byte(8'h22, 0);
        model_idle();
        repeat (TO + 30) tick();
        wait_drain(200);

        // Two frames queued behind a stalled consumer.
        i_ready = 1'b0;
        send_frame(32'hDEADBEEF, 1'b1, 0);
        send_frame(32'hCAFEF00D, 1'b1, 0);
        for (int n = 0; n < 200 && !o_valid; n++) tick();
        check_eq("hold_valid", 32'(o_valid), 32'h1);
        repeat (50) tick();
        check_eq("hold_fifo_kept", 32'(fifo.size()), 32'(NB + 2));
        i_ready = 1'b1;
        wait_drain(300);

        // Reset in the middle of a frame.
        push_byte(SY, 2);
        push_byte(8'h11, 2);
        push_byte(8'h22, 2);
        for (int n = 0; n < 50 && fifo.size() != 0; n++) tick();
        tick();
        i_reset = 1'b1;
        #1;
        check_eq("mid_rst_valid", 32'(o_valid), 32'h0);
        check_eq("mid_rst_rd", 32'(o_rd), 32'h0);
        check_eq("mid_rst_word", o_word, 32'h0);
        m_in = 1'b0;
        repeat (3) tick();
        i_reset = 1'b0;
        tick();
        send_frame(32'h89ABCDEF, 1'b1, 1);
        wait_drain(200);

        // Randomized traffic with random backpressure.
        rand_ready = 1'b1;
        for (int f = 0; f < 40; f++) begin
            logic [7:0] g;
            for (int k = $urandom_range(0, 2); k > 0; k--) begin
                g = 8'($urandom_range(0, 255));
                if (g == SY) g = 8'h5A;
                push_byte(g, $urandom_range(0, 3));
            end
            send_frame($urandom, ($urandom_range(0, 3) != 0), 5);
        end
        wait_drain(5000);
        rand_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
